// File: rtl/function_tester_pkg.sv
// Shared types and constants for the function tester: FSM states, golden table and widths.
package function_tester_pkg;

  localparam int unsigned VEC_W   = 4;
  localparam int unsigned NUM_VEC = 16;
  localparam int unsigned ERR_W   = 5;
  localparam int unsigned CNT_W   = 4;

  localparam logic [NUM_VEC-1:0] DEFAULT_EXPECTED = 16'hDC51;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DRIVE  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

endpackage

// File: rtl/function_tester_rail_driver.sv
// Registers the stimulus vector and drives matched true/complement rails from the same edge.
module rail_driver
  import function_tester_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             clear,
  input  logic [VEC_W-1:0] vec,
  output logic [VEC_W-1:0] true_rail,
  output logic [VEC_W-1:0] comp_rail
);

  // Both rails always update together so they can never be equal.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      true_rail <= '0;
      comp_rail <= '1;
    end else if (load) begin
      true_rail <= vec;
      comp_rail <= ~vec;
    end
  end

endmodule

// File: rtl/function_tester.sv
// Sweeps all 16 input vectors through a 4-input function and compares its response
// against a golden truth table, reporting mismatch count and first failing index.
module function_tester
  import function_tester_pkg::*;
#(
  parameter int unsigned          SETTLE_CYCLES = 2,
  parameter logic [NUM_VEC-1:0]   EXPECTED      = DEFAULT_EXPECTED
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  output logic             a,
  output logic             b,
  output logic             c,
  output logic             d,
  output logic             not_a,
  output logic             not_b,
  output logic             not_c,
  output logic             not_d,
  input  logic             dut_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [VEC_W-1:0] first_fail,
  output logic             fail_valid
);

  state_t             state_q, state_d;
  logic [VEC_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   settle_q, settle_d;
  logic [ERR_W-1:0]   err_q, err_d;
  logic [VEC_W-1:0]   ff_q, ff_d;
  logic               fv_q, fv_d;
  logic               pass_q, pass_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;
  logic               load_c, clear_c;
  logic [VEC_W-1:0]   true_rail, comp_rail;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      settle_q <= '0;
      err_q    <= '0;
      ff_q     <= '0;
      fv_q     <= 1'b0;
      pass_q   <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      settle_q <= settle_d;
      err_q    <= err_d;
      ff_q     <= ff_d;
      fv_q     <= fv_d;
      pass_q   <= pass_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    settle_d = settle_q;
    err_d    = err_q;
    ff_d     = ff_q;
    fv_d     = fv_q;
    pass_d   = pass_q;
    done_d   = 1'b0;
    load_c   = 1'b0;
    clear_c  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          state_d = ST_DRIVE;
          idx_d   = '0;
          err_d   = '0;
          ff_d    = '0;
          fv_d    = 1'b0;
          pass_d  = 1'b0;
          load_c  = 1'b1;
        end
      end
      ST_DRIVE: begin
        state_d  = ST_SETTLE;
        settle_d = CNT_W'(SETTLE_CYCLES);
      end
      ST_SETTLE: begin
        if (settle_q <= CNT_W'(1)) begin
          state_d  = ST_SAMPLE;
          settle_d = '0;
        end else begin
          settle_d = settle_q - CNT_W'(1);
        end
      end
      ST_SAMPLE: begin
        if (dut_out != EXPECTED[idx_q]) begin
          if (err_q != ERR_W'(NUM_VEC)) err_d = err_q + ERR_W'(1);
          if (!fv_q) begin
            ff_d = idx_q;
            fv_d = 1'b1;
          end
        end
        // Final vector: result and done become visible on the same edge.
        if (idx_q == VEC_W'(NUM_VEC - 1)) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          pass_d  = (err_d == '0);
          clear_c = 1'b1;
        end else begin
          state_d = ST_DRIVE;
          idx_d   = idx_q + VEC_W'(1);
          load_c  = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        clear_c = 1'b1;
      end
    endcase

    // Abort discards the sweep but keeps the partial error record.
    if (abort && state_q != ST_IDLE) begin
      state_d  = ST_IDLE;
      idx_d    = idx_q;
      settle_d = '0;
      err_d    = err_q;
      ff_d     = ff_q;
      fv_d     = fv_q;
      pass_d   = 1'b0;
      done_d   = 1'b0;
      load_c   = 1'b0;
      clear_c  = 1'b1;
    end

    busy_d = (state_d != ST_IDLE);
  end

  rail_driver u_rail_driver (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load_c),
    .clear     (clear_c),
    .vec       (idx_d),
    .true_rail (true_rail),
    .comp_rail (comp_rail)
  );

  assign {a, b, c, d}                 = true_rail;
  assign {not_a, not_b, not_c, not_d} = comp_rail;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_count  = err_q;
  assign first_fail = ff_q;
  assign fail_valid = fv_q;

endmodule

// File: tb/tb_function_tester.sv
// Bench for function_tester: the function under test is a truth table chosen per run,
// and results are predicted by comparing that table with the golden one.
module tb_function_tester;

  localparam logic [15:0] GOLD = 16'hDC51;

  logic       clk = 1'b0;
  logic       rst_n, start, abort, dut_out;
  logic       a, b, c, d, not_a, not_b, not_c, not_d;
  logic       busy, done, pass, fail_valid;
  logic [4:0] err_count;
  logic [3:0] first_fail;
  logic [15:0] fut_tt;

  int  n_checks = 0;
  int  n_pass   = 0;
  bit  mon_en   = 1'b0;
  bit  done_prev = 1'b0;
  int  done_pulses = 0;

  typedef struct {
    logic [15:0] tt;
    int          err;
    int          ff;
    int          fv;
    int          ps;
  } vec_t;

  vec_t tbl[4];

  function_tester dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .a(a), .b(b), .c(c), .d(d),
    .not_a(not_a), .not_b(not_b), .not_c(not_c), .not_d(not_d),
    .dut_out(dut_out), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .first_fail(first_fail), .fail_valid(fail_valid)
  );

  assign dut_out = fut_tt[{a, b, c, d}];

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic int ref_err(input logic [15:0] tt);
    logic [15:0] x = tt ^ GOLD;
    int n = 0;
    for (int i = 0; i < 16; i++) n += int'(x[i]);
    return n;
  endfunction

  function automatic int ref_first(input logic [15:0] tt);
    logic [15:0] x = tt ^ GOLD;
    for (int i = 0; i < 16; i++) if (x[i]) return i;
    return 0;
  endfunction

  // Rails must be complementary and done a single-cycle pulse on every cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      check("rails_complement", int'({a ^ not_a, b ^ not_b, c ^ not_c, d ^ not_d}), 15);
      check("done_width", int'(done && done_prev), 0);
      if (done && !done_prev) done_pulses++;
      done_prev = done;
    end
  end

  task automatic check_reset_vals(input string tag);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_pass"}, int'(pass), 0);
    check({tag, "_err"}, int'(err_count), 0);
    check({tag, "_ff"}, int'(first_fail), 0);
    check({tag, "_fv"}, int'(fail_valid), 0);
    check({tag, "_true"}, int'({a, b, c, d}), 0);
    check({tag, "_comp"}, int'({not_a, not_b, not_c, not_d}), 15);
  endtask

  // Pulses start and waits (bounded) for done; restart_at>0 re-pulses start mid-sweep.
  task automatic run_sweep(input int restart_at, output int latency);
    int busy_drop = 0;
    latency = -1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int e = 1; e <= 200; e++) begin
      @(posedge clk); #1;
      start = (e == restart_at) ? 1'b1 : 1'b0;
      if (!busy) busy_drop++;
      if (done) begin
        latency = e;
        break;
      end
    end
    start = 1'b0;
    check("busy_during_sweep", busy_drop, 0);
  endtask

  task automatic sweep_and_check(input string tag, input logic [15:0] tt, input int exp_err,
                                 input int exp_ff, input int exp_fv, input int exp_pass,
                                 input int restart_at);
    int lat;
    int pulses0;
    fut_tt  = tt;
    pulses0 = done_pulses;
    run_sweep(restart_at, lat);
    check({tag, "_latency"}, lat, 64);
    check({tag, "_err"}, int'(err_count), exp_err);
    check({tag, "_fv"}, int'(fail_valid), exp_fv);
    if (exp_fv != 0) check({tag, "_ff"}, int'(first_fail), exp_ff);
    check({tag, "_pass"}, int'(pass), exp_pass);
    repeat (8) begin
      @(posedge clk); #1;
    end
    check({tag, "_busy_after"}, int'(busy), 0);
    check({tag, "_pass_hold"}, int'(pass), exp_pass);
    check({tag, "_single_done"}, done_pulses - pulses0, 1);
  endtask

  initial begin
    logic [15:0] rtt;
    int pulses0;
    tbl[0] = '{tt: GOLD,             err: 0, ff: 0,  fv: 0, ps: 1};
    tbl[1] = '{tt: 16'h0000,         err: 8, ff: 0,  fv: 1, ps: 0};
    tbl[2] = '{tt: 16'hFFFF,         err: 8, ff: 1,  fv: 1, ps: 0};
    tbl[3] = '{tt: 16'hD851,         err: 1, ff: 10, fv: 1, ps: 0};

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; fut_tt = GOLD;
    repeat (3) @(posedge clk);
    #1;
    mon_en = 1'b1;
    check_reset_vals("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 4; i++)
      sweep_and_check($sformatf("table%0d", i), tbl[i].tt, tbl[i].err, tbl[i].ff,
                      tbl[i].fv, tbl[i].ps, 0);

    for (int i = 0; i < 6; i++) begin
      rtt = 16'($urandom);
      if (i == 0) rtt = GOLD ^ (16'h1 << $urandom_range(0, 15));
      sweep_and_check($sformatf("rand%0d", i), rtt, ref_err(rtt), ref_first(rtt),
                      int'(ref_err(rtt) != 0), int'(ref_err(rtt) == 0), 0);
    end

    rtt = 16'($urandom);
    sweep_and_check("restart", rtt, ref_err(rtt), ref_first(rtt),
                    int'(ref_err(rtt) != 0), int'(ref_err(rtt) == 0), 20);

    // start and abort together in idle: abort wins
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    check("start_abort_idle", int'(busy), 0);
    @(posedge clk); #1;
    check("start_abort_idle2", int'(busy), 0);

    // abort while vector 5 settles: vectors 0..4 already scored against stuck-at-0
    fut_tt  = 16'h0000;
    pulses0 = done_pulses;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int e = 1; e <= 21; e++) begin
      @(posedge clk); #1;
      if (e == 21) abort = 1'b1;
    end
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_pass", int'(pass), 0);
    check("abort_err", int'(err_count), 2);
    check("abort_ff", int'(first_fail), 0);
    check("abort_fv", int'(fail_valid), 1);
    check("abort_rails", int'({a, b, c, d}), 0);
    repeat (80) @(posedge clk);
    #1;
    check("abort_no_done", done_pulses - pulses0, 0);

    // reset during vector 9 with start held high in the reset cycle
    fut_tt  = 16'h0000;
    pulses0 = done_pulses;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int e = 1; e <= 38; e++) begin
      @(posedge clk); #1;
      if (e == 38) begin
        rst_n = 1'b0;
        start = 1'b1;
      end
    end
    @(posedge clk); #1;
    check_reset_vals("midreset");
    rst_n = 1'b1;
    start = 1'b0;
    @(posedge clk); #1;
    check("reset_start_ignored", int'(busy), 0);
    repeat (80) @(posedge clk);
    #1;
    check("reset_no_done", done_pulses - pulses0, 0);

    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
